// File: rtl/ram_io_responder.sv
// Target side of the CPU byte bus: 128KB RAM, UART RX/TX byte FIFOs, free-running cycle counter
// and program stop. Accepted reads land in the registered mem_din one edge after the address.
module ram_io_responder #(
  parameter int          RAM_AW   = 17,
  parameter int          TX_DEPTH = 8,
  parameter int          RX_DEPTH = 8,
  parameter logic [31:0] CNT_INIT = 32'h0000_0000
) (
  input  logic        clk_in,
  input  logic        rst_in_n,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        cpu_rdy,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        prog_stop
);
  localparam int TX_PW = $clog2(TX_DEPTH);
  localparam int RX_PW = $clog2(RX_DEPTH);
  localparam logic [TX_PW:0] TX_FULL = (TX_PW+1)'(TX_DEPTH);
  localparam logic [RX_PW:0] RX_FULL = (RX_PW+1)'(RX_DEPTH);

  logic [7:0]       r_ram    [0:(1<<RAM_AW)-1];
  logic [7:0]       r_tx_mem [0:TX_DEPTH-1];
  logic [7:0]       r_rx_mem [0:RX_DEPTH-1];
  logic [TX_PW-1:0] r_tx_wp, r_tx_rp;
  logic [RX_PW-1:0] r_rx_wp, r_rx_rp;
  logic [TX_PW:0]   r_tx_cnt;
  logic [RX_PW:0]   r_rx_cnt;
  logic [31:0]      r_cnt;
  logic [31:8]      r_snap;
  logic [7:0]       r_din;
  logic             r_rdy;
  logic             r_stop;

  logic             w_rd, w_wr, w_is_ram, w_is_io;
  logic [2:0]       w_off;
  logic             w_rx_push, w_rx_pop, w_tx_push, w_tx_pop, w_stop_wr;
  logic [7:0]       w_tx_wdata, w_ram_rdata, w_io_rdata;
  logic [TX_PW:0]   w_tx_cnt_nxt;
  logic [RX_PW:0]   w_rx_cnt_nxt;
  logic             w_stop_nxt;
  logic             w_unused_addr;

  // Handshakes: a host byte moves when rx_valid && rx_ready, a UART byte when tx_valid && tx_ready,
  // and a bus cycle is accepted only while cpu_rdy is high; all three are sampled at the same edge.
  assign mem_din   = r_din;
  assign cpu_rdy   = r_rdy;
  assign prog_stop = r_stop;
  assign tx_valid  = (r_tx_cnt != '0);
  assign tx_data   = r_tx_mem[r_tx_rp];
  assign rx_ready  = (r_rx_cnt != RX_FULL);

  assign w_unused_addr = ^mem_a[31:18];
  assign w_rd     = r_rdy & ~mem_wr;
  assign w_wr     = r_rdy & mem_wr;
  assign w_is_ram = ~mem_a[17];
  assign w_is_io  = (mem_a[17:16] == 2'b11);
  assign w_off    = mem_a[2:0];

  assign w_rx_push  = rx_valid & rx_ready;
  assign w_rx_pop   = w_rd & w_is_io & (w_off == 3'd0) & (r_rx_cnt != '0);
  assign w_stop_wr  = w_wr & w_is_io & (w_off == 3'd4);
  assign w_tx_push  = w_stop_wr | (w_wr & w_is_io & (w_off == 3'd0) & (mem_dout != 8'h00));
  assign w_tx_wdata = w_stop_wr ? 8'h00 : mem_dout;
  assign w_tx_pop   = tx_valid & tx_ready;

  assign w_tx_cnt_nxt = r_tx_cnt + (TX_PW+1)'(w_tx_push) - (TX_PW+1)'(w_tx_pop);
  assign w_rx_cnt_nxt = r_rx_cnt + (RX_PW+1)'(w_rx_push) - (RX_PW+1)'(w_rx_pop);
  assign w_stop_nxt   = r_stop | w_stop_wr;

  assign w_ram_rdata = r_ram[mem_a[RAM_AW-1:0]];

  // Offset 4 returns the live counter low byte; offsets 5..7 come from the snapshot it reloads.
  always_comb begin
    w_io_rdata = 8'h00;
    case (w_off)
      3'd0:    if (r_rx_cnt != '0) w_io_rdata = r_rx_mem[r_rx_rp];
      3'd4:    w_io_rdata = r_cnt[7:0];
      3'd5:    w_io_rdata = r_snap[15:8];
      3'd6:    w_io_rdata = r_snap[23:16];
      3'd7:    w_io_rdata = r_snap[31:24];
      default: w_io_rdata = 8'h00;
    endcase
  end

  // Storage arrays carry no reset: RAM survives reset, FIFO slots are discarded via the pointers.
  always_ff @(posedge clk_in) begin
    if (w_wr && w_is_ram) r_ram[mem_a[RAM_AW-1:0]] <= mem_dout;
    if (w_tx_push)        r_tx_mem[r_tx_wp]         <= w_tx_wdata;
    if (w_rx_push)        r_rx_mem[r_rx_wp]         <= rx_data;
  end

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      r_din    <= 8'h00;
      r_rdy    <= 1'b0;
      r_stop   <= 1'b0;
      r_cnt    <= CNT_INIT;
      r_snap   <= '0;
      r_tx_wp  <= '0;
      r_tx_rp  <= '0;
      r_tx_cnt <= '0;
      r_rx_wp  <= '0;
      r_rx_rp  <= '0;
      r_rx_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 32'd1;
      if (w_rd) begin
        if (w_is_ram)     r_din <= w_ram_rdata;
        else if (w_is_io) r_din <= w_io_rdata;
        else              r_din <= 8'h00;
        if (w_is_io && (w_off == 3'd4)) r_snap <= r_cnt[31:8];
      end
      if (w_tx_push) r_tx_wp <= r_tx_wp + TX_PW'(1);
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + TX_PW'(1);
      if (w_rx_push) r_rx_wp <= r_rx_wp + RX_PW'(1);
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + RX_PW'(1);
      r_tx_cnt <= w_tx_cnt_nxt;
      r_rx_cnt <= w_rx_cnt_nxt;
      r_stop   <= w_stop_nxt;
      // Holding rdy low whenever the TX FIFO will be full means an accepted push always has a slot.
      r_rdy    <= ~w_stop_nxt & (w_tx_cnt_nxt != TX_FULL);
    end
  end
endmodule
